// File: rtl/frame_scanner_pkg.sv
// frame_scanner shared constants: opcodes, screen geometry, field widths,
// FSM state encodings and the instruction-word builder.
package frame_scanner_pkg;

    localparam int SCREEN_WIDTH      = 160;
    localparam int SCREEN_HEIGHT     = 120;
    localparam int X_WIDTH           = 8;
    localparam int Y_WIDTH           = 7;
    localparam int COLOUR_WIDTH      = 3;
    localparam int INSTRUCTION_WIDTH = 32;

    localparam logic [3:0] OPCODE_DRAW    = 4'h1;
    localparam logic [3:0] OPCODE_DISPLAY = 4'h2;

    typedef enum logic [2:0] {
        FS_STATE_IDLE      = 3'd0,
        FS_STATE_ARM       = 3'd1,
        FS_STATE_ISSUE     = 3'd2,
        FS_STATE_WAIT_ACK  = 3'd3,
        FS_STATE_WAIT_DONE = 3'd4,
        FS_STATE_DONE      = 3'd5
    } fs_state_t;

    function automatic logic [INSTRUCTION_WIDTH-1:0] make_instr(
        input logic                    clr,
        input logic [COLOUR_WIDTH-1:0] colour,
        input logic [X_WIDTH-1:0]      x,
        input logic [Y_WIDTH-1:0]      y
    );
        logic [INSTRUCTION_WIDTH-1:0] w;
        w        = '0;
        w[3:0]   = clr ? OPCODE_DRAW : OPCODE_DISPLAY;
        w[11:4]  = x;
        w[18:12] = y;
        if (clr) begin
            w[21:19] = colour;
            w[22]    = 1'b1;
        end
        return w;
    endfunction

endpackage

// File: rtl/frame_scanner_raster_counter.sv
// raster_counter: x/y raster position, x fastest, with clear, advance,
// next-position lookahead and a last-pixel flag.
module raster_counter #(
    parameter int W  = 160,
    parameter int H  = 120,
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [XW-1:0] o_nx,
    output logic [YW-1:0] o_ny,
    output logic          o_last
);

    localparam logic [XW-1:0] XMAX = XW'(W - 1);
    localparam logic [YW-1:0] YMAX = YW'(H - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_xend;
    logic          w_yend;

    // Row-end / frame-end detection and the position after an advance
    always_comb begin
        w_xend = (r_x == XMAX);
        w_yend = (r_y == YMAX);
        o_nx   = w_xend ? '0 : r_x + XW'(1);
        o_ny   = w_xend ? r_y + YW'(1) : r_y;
        o_last = w_xend && w_yend;
    end

    // Position register: clear restarts at (0,0), advance steps raster order
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            r_x <= o_nx;
            r_y <= o_ny;
        end
    end

    assign o_x = r_x;
    assign o_y = r_y;

endmodule

// File: rtl/frame_scanner.sv
// frame_scanner: walks the framebuffer issuing one display/draw op per pixel.
// Optional FRAME_SCANNER_AUTO_REPEAT_EN adds repeat_en for back-to-back frames.
module frame_scanner
    import frame_scanner_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_WIDTH,
    parameter int SCREEN_H = SCREEN_HEIGHT,
    parameter int X_W      = X_WIDTH,
    parameter int Y_W      = Y_WIDTH
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        go,
    input  logic        mode,
    input  logic [2:0]  clear_colour,
    input  logic        dp_finished,
`ifdef FRAME_SCANNER_AUTO_REPEAT_EN
    input  logic        repeat_en,
`endif
    output logic        dp_start,
    output logic [31:0] dp_instruction,
    output logic        busy,
    output logic        done
);

    fs_state_t   r_state;
    fs_state_t   w_next;
    logic        r_mode;
    logic [2:0]  r_colour;
    logic        r_dp_start;
    logic [31:0] r_instr;
    logic        r_busy;
    logic        r_done;

    logic        w_clr;
    logic        w_adv;
    logic        w_latch;
    logic        w_busy_n;
    logic        w_last;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic [X_W-1:0] w_nx;
    logic [Y_W-1:0] w_ny;
    logic [X_W-1:0] w_ix;
    logic [Y_W-1:0] w_iy;

    raster_counter #(
        .W  (SCREEN_W),
        .H  (SCREEN_H),
        .XW (X_W),
        .YW (Y_W)
    ) u_raster (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_clr   (w_clr),
        .i_adv   (w_adv),
        .o_x     (w_x),
        .o_y     (w_y),
        .o_nx    (w_nx),
        .o_ny    (w_ny),
        .o_last  (w_last)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= FS_STATE_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, counter control and next values of the registered outputs
    always_comb begin
        w_next  = r_state;
        w_clr   = 1'b0;
        w_adv   = 1'b0;
        w_latch = 1'b0;
        unique case (r_state)
            FS_STATE_IDLE: begin
                if (go) begin
                    w_next  = FS_STATE_ARM;
                    w_clr   = 1'b1;
                    w_latch = 1'b1;
                end
            end
            FS_STATE_ARM: begin
                if (dp_finished) begin
                    w_next = FS_STATE_ISSUE;
                end
            end
            FS_STATE_ISSUE: begin
                w_next = FS_STATE_WAIT_ACK;
            end
            FS_STATE_WAIT_ACK: begin
                if (!dp_finished) begin
                    w_next = FS_STATE_WAIT_DONE;
                end
            end
            FS_STATE_WAIT_DONE: begin
                if (dp_finished) begin
                    if (w_last) begin
                        w_next = FS_STATE_DONE;
                    end else begin
                        w_adv  = 1'b1;
                        w_next = FS_STATE_ISSUE;
                    end
                end
            end
            FS_STATE_DONE: begin
                w_next = FS_STATE_IDLE;
`ifdef FRAME_SCANNER_AUTO_REPEAT_EN
                if (repeat_en) begin
                    w_next = FS_STATE_ARM;
                    w_clr  = 1'b1;
                end
`endif
            end
            default: begin
                w_next = FS_STATE_IDLE;
            end
        endcase
        // The word for the pixel being issued uses the post-advance position
        w_ix     = w_adv ? w_nx : w_x;
        w_iy     = w_adv ? w_ny : w_y;
        w_busy_n = (w_next != FS_STATE_IDLE) && (w_next != FS_STATE_DONE);
`ifdef FRAME_SCANNER_AUTO_REPEAT_EN
        if ((w_next == FS_STATE_DONE) && repeat_en) begin
            w_busy_n = 1'b1;
        end
`endif
    end

    // Registered outputs and the mode/colour latched at go
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_dp_start <= 1'b0;
            r_instr    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mode     <= 1'b0;
            r_colour   <= '0;
        end else begin
            r_dp_start <= (w_next == FS_STATE_ISSUE);
            r_busy     <= w_busy_n;
            r_done     <= (w_next == FS_STATE_DONE);
            if (w_next == FS_STATE_ISSUE) begin
                r_instr <= make_instr(r_mode, r_colour, 8'(w_ix), 7'(w_iy));
            end
            if (w_latch) begin
                r_mode   <= mode;
                r_colour <= clear_colour;
            end
        end
    end

    assign dp_start       = r_dp_start;
    assign dp_instruction = r_instr;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_frame_scanner.sv
// Self-checking bench for frame_scanner on a 4x3 screen with a 2-phase
// datapath model and a framebuffer model.
module tb_frame_scanner;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;
    localparam logic [3:0] OP_DRAW = 4'h1;
    localparam logic [3:0] OP_DISP = 4'h2;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        go = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  clear_colour = 3'd0;
    logic        dp_finished;
    logic        dp_start;
    logic [31:0] dp_instruction;
    logic        busy;
    logic        done;
`ifdef FRAME_SCANNER_AUTO_REPEAT_EN
    logic        repeat_en = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    frame_scanner #(
        .SCREEN_W (W),
        .SCREEN_H (H),
        .X_W      (8),
        .Y_W      (7)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .go             (go),
        .mode           (mode),
        .clear_colour   (clear_colour),
        .dp_finished    (dp_finished),
`ifdef FRAME_SCANNER_AUTO_REPEAT_EN
        .repeat_en      (repeat_en),
`endif
        .dp_start       (dp_start),
        .dp_instruction (dp_instruction),
        .busy           (busy),
        .done           (done)
    );

    // Datapath model: finished drops the cycle after start, returns 3 cycles after
    int         dp_cnt = 0;
    logic       dp_idle = 1'b1;
    logic       hold_low = 1'b0;
    logic       fb_init = 1'b0;
    logic [2:0] fb_fill = 3'd0;
    logic [2:0] fb [H][W];

    assign dp_finished = dp_idle & ~hold_low;

    always @(posedge clock) begin
        if (fb_init) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    fb[r][c] <= fb_fill;
        end
        if (dp_start) begin
            dp_cnt  <= 2;
            dp_idle <= 1'b0;
            if (dp_instruction[3:0] == OP_DRAW && dp_instruction[22])
                fb[int'(dp_instruction[18:12])][int'(dp_instruction[11:4])]
                    <= dp_instruction[21:19];
        end else if (dp_cnt > 0) begin
            dp_cnt <= dp_cnt - 1;
            if (dp_cnt == 1) dp_idle <= 1'b1;
        end
    end

    function automatic logic [31:0] ref_word(bit m, int c, int x, int y);
        int w;
        w = (m ? int'(OP_DRAW) : int'(OP_DISP)) + x * 16 + y * 4096;
        if (m) w = w + c * 524288 + 4194304;
        return 32'(w);
    endfunction

    // One full frame: instruction stream, issue timing, done and busy
    task automatic run_frame(input bit m, input int c, input int stall,
                             input bit disturb, input string tag);
        logic [31:0] got[$];
        int          gcyc[$];
        int          first, done_exp, dcnt, dcyc, busy_err;
        logic [31:0] act;
        int          acyc;
        first    = (stall > 0) ? stall + 1 : 2;
        done_exp = first + 4 * N;
        dcnt = 0; dcyc = -1; busy_err = 0;
        @(posedge clock); #1;
        go = 1'b1; mode = m; clear_colour = 3'(c);
        if (stall > 0) hold_low = 1'b1;
        for (int cyc = 1; cyc <= done_exp + 4; cyc++) begin
            @(posedge clock); #1;
            if (cyc == 1) go = 1'b0;
            if (cyc == stall) hold_low = 1'b0;
            if (disturb && cyc > 1) begin
                if (cyc < done_exp) begin
                    go = 1'($urandom_range(0, 1));
                    mode = 1'($urandom_range(0, 1));
                    clear_colour = 3'($urandom_range(0, 7));
                end else if (cyc == done_exp) begin
                    go = 1'b1;
                end else begin
                    go = 1'b0;
                end
            end
            if (dp_start) begin
                got.push_back(dp_instruction);
                gcyc.push_back(cyc);
            end
            if (done) begin dcnt++; dcyc = cyc; end
            if (busy !== (cyc < done_exp)) busy_err++;
        end
        go = 1'b0; mode = 1'b0; clear_colour = 3'd0;
        vectors++;
        if (got.size() != N) begin
            miscompares++;
            $display("FAIL %s start_count got %0d want %0d", tag, got.size(), N);
        end
        for (int i = 0; i < N; i++) begin
            act  = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
            acyc = (i < gcyc.size()) ? gcyc[i] : -1;
            vectors++;
            if (act !== ref_word(m, c, i % W, i / W)) begin
                miscompares++;
                $display("FAIL %s instr[%0d] got %h want %h", tag, i, act,
                         ref_word(m, c, i % W, i / W));
            end
            vectors++;
            if (acyc != first + 4 * i) begin
                miscompares++;
                $display("FAIL %s issue_cycle[%0d] got %0d want %0d", tag, i,
                         acyc, first + 4 * i);
            end
        end
        vectors++;
        if (dcnt != 1 || dcyc != done_exp) begin
            miscompares++;
            $display("FAIL %s done got %0d pulses at %0d want 1 at %0d", tag,
                     dcnt, dcyc, done_exp);
        end
        vectors++;
        if (busy_err != 0) begin
            miscompares++;
            $display("FAIL %s busy got %0d bad cycles want 0", tag, busy_err);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        vectors += 4;
        if (dp_start !== 1'b0) begin miscompares++;
            $display("FAIL reset dp_start got %b want 0", dp_start); end
        if (dp_instruction !== 32'd0) begin miscompares++;
            $display("FAIL reset instr got %h want 0", dp_instruction); end
        if (busy !== 1'b0) begin miscompares++;
            $display("FAIL reset busy got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++;
            $display("FAIL reset done got %b want 0", done); end
        resetn = 1'b1;
    endtask

    task automatic test_display();
        run_frame(1'b0, 0, 0, 1'b0, "display");
    endtask

    task automatic test_clear(input int c, input string tag);
        fb_fill = ~3'(c); fb_init = 1'b1;
        @(posedge clock); #1;
        fb_init = 1'b0;
        run_frame(1'b1, c, 0, 1'b0, tag);
        for (int r = 0; r < H; r++)
            for (int x = 0; x < W; x++) begin
                vectors++;
                if (fb[r][x] !== 3'(c)) begin
                    miscompares++;
                    $display("FAIL %s fb[%0d][%0d] got %0d want %0d", tag, r, x,
                             fb[r][x], c);
                end
            end
    endtask

    task automatic test_stall();
        run_frame(1'b0, 0, 10, 1'b0, "stall");
    endtask

    task automatic test_disturb();
        run_frame(1'b1, int'($urandom_range(0, 7)), 0, 1'b1, "disturb");
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        found = 1'b0;
        @(posedge clock); #1;
        go = 1'b1; mode = 1'b0;
        for (int cyc = 1; cyc < 200 && !found; cyc++) begin
            @(posedge clock); #1;
            if (cyc == 1) go = 1'b0;
            if (dp_start && dp_instruction[11:4] == 8'd2 &&
                dp_instruction[18:12] == 7'd1) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL midreset pixel(2,1) got none want issue");
        end
        resetn = 1'b0;
        @(posedge clock); #1;
        vectors += 3;
        if (dp_start !== 1'b0) begin miscompares++;
            $display("FAIL midreset dp_start got %b want 0", dp_start); end
        if (busy !== 1'b0) begin miscompares++;
            $display("FAIL midreset busy got %b want 0", busy); end
        if (dp_instruction !== 32'd0) begin miscompares++;
            $display("FAIL midreset instr got %h want 0", dp_instruction); end
        resetn = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        run_frame(1'b0, 0, 0, 1'b0, "restart");
    endtask

`ifdef FRAME_SCANNER_AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int dc[$];
        int busy_err;
        logic [31:0] w52;
        busy_err = 0; w52 = 32'hxxxxxxxx;
        repeat_en = 1'b1;
        @(posedge clock); #1;
        go = 1'b1; mode = 1'b0;
        for (int cyc = 1; cyc <= 104; cyc++) begin
            @(posedge clock); #1;
            if (cyc == 1) go = 1'b0;
            if (cyc == 60) repeat_en = 1'b0;
            if (done) dc.push_back(cyc);
            if (cyc == 52 && dp_start) w52 = dp_instruction;
            if (busy !== (cyc < 100)) busy_err++;
        end
        vectors += 3;
        if (dc.size() != 2 || dc[0] != 50 || dc[1] != 100) begin
            miscompares++;
            $display("FAIL repeat done got %0d pulses want 2 at 50,100", dc.size());
        end
        if (busy_err != 0) begin
            miscompares++;
            $display("FAIL repeat busy got %0d bad cycles want 0", busy_err);
        end
        if (w52 !== ref_word(1'b0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL repeat frame2_first got %h want %h", w52,
                     ref_word(1'b0, 0, 0, 0));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_display();
        test_clear(5, "clear5");
        test_clear(int'($urandom_range(0, 7)), "clear_rand");
        test_stall();
        test_disturb();
        test_reset_mid_frame();
`ifdef FRAME_SCANNER_AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
